full_dummy_project_top: RTL and testbench
=========================================

FULL_DUMMY_PROJECT_TOP -- requirements
Module: full_dummy_project_top

Interface
REQ-001 Parameters SHALL be: N_ENTRIES, default 16, entries processed per bx; READ_LATENCY, default 2, clock cycles from read address/enable to valid read data of both input memories.
REQ-002 clk  input  1  rising-edge clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en_proc  input  1  processing enable; 0 = no new reads issued.
REQ-005 bx_in  input  2  bunch-crossing tag; one value is held per event period.
REQ-006 bx_out  output  1  page bit (bx[0]) of the event currently being written.
REQ-007 mem1_enb, mem2_enb  output  1 each  read enable of input memories 1 and 2.
REQ-008 mem1_readaddr, mem2_readaddr  output  5 each  read address of input memories 1 and 2.
REQ-009 mem1_dout, mem2_dout  input  32 each  read data, valid READ_LATENCY cycles after the address.
REQ-010 memout_ena, memout_wea  output  1 each  write enable of the 2-page output memory.
REQ-011 memout_writeaddr  output  5  output write address {page, entry[3:0]}.
REQ-012 memout_din  output  32  output write data.

Function
REQ-013 bx_in SHALL be registered every cycle into bx_q; an event start SHALL be detected when en_proc=1 and bx_in != bx_q, or on the first en_proc=1 cycle after reset.
REQ-014 On event start, the block SHALL latch page = bx_in[0] and clear the read counter rd_cnt to 0 in the next cycle.
REQ-015 While an event is active and en_proc=1, the block SHALL issue one read per cycle: both read addresses = {page, rd_cnt[3:0]}, both enb = 1, rd_cnt incremented by 1.
REQ-016 After rd_cnt = N_ENTRIES-1 has been issued, the event SHALL go idle; enb SHALL be 0 and no further reads SHALL be issued until the next event start.
REQ-017 Each issued read SHALL carry a valid bit, page bit and 4-bit index through a delay line of READ_LATENCY stages aligned to the returned data.
REQ-018 When the delayed valid bit is 1, the block SHALL register, one cycle later: memout_din = (mem1_dout + mem2_dout) mod 2^32, memout_writeaddr = {delayed page, delayed index}, memout_ena = memout_wea = 1.
REQ-019 Read-address-to-write latency SHALL be READ_LATENCY+1 cycles (3 at default); throughput one entry per cycle.
REQ-020 When no delayed valid bit is present, memout_ena and memout_wea SHALL be 0; memout_din and memout_writeaddr SHALL hold their last values.
REQ-021 bx_out SHALL update to the delayed page bit on the cycle of the first write of each event and hold it until the next event's first write.
REQ-022 A new event start while reads are outstanding SHALL abort the remaining reads of the old event, restart at index 0 with the new page, and let already-issued reads complete their writes.
REQ-023 en_proc falling to 0 mid-event SHALL stop new reads (enb=0, rd_cnt held); in-flight reads SHALL still be written; reads SHALL resume from the held rd_cnt when en_proc returns to 1 with no bx change.
REQ-024 Addition overflow SHALL wrap silently; rd_cnt SHALL never exceed N_ENTRIES-1.

Reset
REQ-025 While reset=1, all outputs SHALL be 0, delay-line valid bits cleared, event idle, bx_q = 0, first-event flag set.
REQ-026 Reset asserted mid-event SHALL discard all in-flight reads; no write SHALL occur during the reset cycle or the cycle after.

Verification
REQ-027 Memories preloaded mem1 = all 5, mem2 = all 7; release reset, en_proc=1, bx_in=2 -> 16 writes, addr 0..15, data 0x0000000C, bx_out=0, first write 3 cycles after first read.
REQ-028 bx_in 2->3 after 16 cycles -> reads at addresses 16..31, writes to addr 16..31 with data 0x0000000C, bx_out=1.
REQ-029 mem1[k] = 0xFFFFFFFF, mem2[k] = 1 -> memout_din = 0x00000000 at that entry (wrap).
REQ-030 bx change after 8 reads -> old page gets exactly 8 writes (idx 0..7), new page restarts at idx 0.
REQ-031 en_proc low for 4 cycles mid-event -> enb=0 for those 4 cycles, no skipped or duplicated indices, 16 writes total.
REQ-032 Reset pulse mid-event -> all outputs 0 next cycle, no stray writes afterwards.

Source files
------------

// File: rtl/full_dummy_project_top.sv
// Event-paged read/sum/write engine: reads two input memories per entry and
// writes their 32-bit sum into a 2-page output memory selected by bx[0].
module full_dummy_project_top #(
    parameter int N_ENTRIES    = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_proc,
    input  logic [1:0]  bx_in,
    output logic        bx_out,
    output logic        mem1_enb,
    output logic [4:0]  mem1_readaddr,
    input  logic [31:0] mem1_dout,
    output logic        mem2_enb,
    output logic [4:0]  mem2_readaddr,
    input  logic [31:0] mem2_dout,
    output logic        memout_ena,
    output logic        memout_wea,
    output logic [4:0]  memout_writeaddr,
    output logic [31:0] memout_din
);

    localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [1:0]  bx_q;
    logic        first_evt;
    logic        page;
    logic [3:0]  rd_cnt;
    logic        start;

    logic [READ_LATENCY-1:0] dl_valid;
    logic [READ_LATENCY-1:0] dl_page;
    logic [3:0]              dl_idx [READ_LATENCY];

    always_comb begin
        start = 1'b0;
        if (en_proc && (first_evt || (bx_in != bx_q)))
            start = 1'b1;
    end

    // A start cycle never issues a read; reads of an aborted event simply stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bx_q          <= '0;
            first_evt     <= 1'b1;
            page          <= 1'b0;
            rd_cnt        <= '0;
            mem1_enb      <= 1'b0;
            mem2_enb      <= 1'b0;
            mem1_readaddr <= '0;
            mem2_readaddr <= '0;
        end else begin
            bx_q     <= bx_in;
            mem1_enb <= 1'b0;
            mem2_enb <= 1'b0;
            if (start) begin
                first_evt <= 1'b0;
                page      <= bx_in[0];
                rd_cnt    <= '0;
                state     <= RUN;
            end else if (state == RUN && en_proc) begin
                mem1_enb      <= 1'b1;
                mem2_enb      <= 1'b1;
                mem1_readaddr <= {page, rd_cnt};
                mem2_readaddr <= {page, rd_cnt};
                if (rd_cnt == LAST_IDX)
                    state <= IDLE;
                else
                    rd_cnt <= rd_cnt + 4'd1;
            end
        end
    end

    // Tags are taken from the registered read outputs, so stage READ_LATENCY-1
    // lines up with the cycle in which the memories present the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_valid <= '0;
            dl_page  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++)
                dl_idx[i] <= '0;
        end else begin
            dl_valid[0] <= mem1_enb;
            dl_page[0]  <= mem1_readaddr[4];
            dl_idx[0]   <= mem1_readaddr[3:0];
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_page[i]  <= dl_page[i-1];
                dl_idx[i]   <= dl_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_out           <= 1'b0;
            memout_ena       <= 1'b0;
            memout_wea       <= 1'b0;
            memout_writeaddr <= '0;
            memout_din       <= '0;
        end else begin
            memout_ena <= 1'b0;
            memout_wea <= 1'b0;
            if (dl_valid[READ_LATENCY-1]) begin
                memout_ena       <= 1'b1;
                memout_wea       <= 1'b1;
                memout_din       <= mem1_dout + mem2_dout;
                memout_writeaddr <= {dl_page[READ_LATENCY-1], dl_idx[READ_LATENCY-1]};
                bx_out           <= dl_page[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_full_dummy_project_top.sv
// Directed bench for full_dummy_project_top with a 2-cycle-latency memory model.
module tb_full_dummy_project_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_proc;
    logic [1:0]  bx_in;
    logic        bx_out;
    logic        mem1_enb, mem2_enb;
    logic [4:0]  mem1_readaddr, mem2_readaddr;
    logic [31:0] mem1_dout, mem2_dout;
    logic        memout_ena, memout_wea;
    logic [4:0]  memout_writeaddr;
    logic [31:0] memout_din;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] m1_s1, m1_s2, m2_s1, m2_s2;

    int          rd_addr_q[$];
    int          rd2_addr_q[$];
    int          rd_cyc_q[$];
    int          wr_addr_q[$];
    int          wr_cyc_q[$];
    int          wr_bx_q[$];
    int          wr_we_q[$];
    logic [31:0] wr_data_q[$];

    full_dummy_project_top #(.N_ENTRIES(16), .READ_LATENCY(2)) dut (
        .clk(clk),
        .reset(reset),
        .en_proc(en_proc),
        .bx_in(bx_in),
        .bx_out(bx_out),
        .mem1_enb(mem1_enb),
        .mem1_readaddr(mem1_readaddr),
        .mem1_dout(mem1_dout),
        .mem2_enb(mem2_enb),
        .mem2_readaddr(mem2_readaddr),
        .mem2_dout(mem2_dout),
        .memout_ena(memout_ena),
        .memout_wea(memout_wea),
        .memout_writeaddr(memout_writeaddr),
        .memout_din(memout_din)
    );

    always #5 clk = ~clk;

    // Memory data is valid two cycles after the address is presented.
    always @(posedge clk) begin
        m1_s1 <= mem1[mem1_readaddr];
        m2_s1 <= mem2[mem2_readaddr];
        m1_s2 <= m1_s1;
        m2_s2 <= m2_s1;
    end
    assign mem1_dout = m1_s2;
    assign mem2_dout = m2_s2;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (mem1_enb) begin
            rd_addr_q.push_back(int'(mem1_readaddr));
            rd2_addr_q.push_back(mem2_enb ? int'(mem2_readaddr) : -1);
            rd_cyc_q.push_back(cyc);
        end
        if (memout_ena) begin
            wr_addr_q.push_back(int'(memout_writeaddr));
            wr_data_q.push_back(memout_din);
            wr_bx_q.push_back(int'(bx_out));
            wr_we_q.push_back(int'(memout_wea));
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        rd_addr_q.delete(); rd2_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_bx_q.delete();
        wr_we_q.delete(); wr_cyc_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_mem();
        for (int k = 0; k < 32; k++) begin
            mem1[k] = 32'd5;
            mem2[k] = 32'd7;
        end
    endtask

    task automatic wait_read(input logic [4:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem1_enb && mem1_readaddr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en_proc = 1'b0; bx_in = 2'd0;
        tick(3);
        vectors++;
        if ({bx_out, mem1_enb, mem2_enb, mem1_readaddr, mem2_readaddr, memout_ena,
             memout_wea, memout_writeaddr, memout_din} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ena=%b enb=%b waddr=%0d din=%h bx_out=%b, expected all 0",
                     memout_ena, mem1_enb, memout_writeaddr, memout_din, bx_out);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        clear_logs();
        en_proc = 1'b1; bx_in = 2'd2;
        tick(30);
        vectors++;
        if (rd_addr_q.size() != 16 || wr_addr_q.size() != 16) begin
            miscompares++;
            $display("FAIL basic_counts: reads=%0d writes=%0d, expected 16/16", rd_addr_q.size(), wr_addr_q.size());
        end
        for (int k = 0; k < 16 && k < rd_addr_q.size() && k < wr_addr_q.size(); k++) begin
            vectors++;
            if (rd_addr_q[k] != k || rd2_addr_q[k] != k || wr_addr_q[k] != k || wr_data_q[k] !== 32'h0000000C
                || wr_bx_q[k] != 0 || wr_we_q[k] != 1) begin
                miscompares++;
                $display("FAIL basic_entry%0d: rd=%0d rd2=%0d wr=%0d data=%h bx=%0d we=%0d, expected %0d %0d %0d 0000000c 0 1",
                         k, rd_addr_q[k], rd2_addr_q[k], wr_addr_q[k], wr_data_q[k], wr_bx_q[k], wr_we_q[k], k, k, k);
            end
        end
        if (rd_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
            vectors++;
            if (wr_cyc_q[0] - rd_cyc_q[0] != 3) begin
                miscompares++;
                $display("FAIL basic_latency: got %0d cycles, expected 3", wr_cyc_q[0] - rd_cyc_q[0]);
            end
        end
    endtask

    task automatic test_page_switch();
        clear_logs();
        bx_in = 2'd3;
        tick(30);
        vectors++;
        if (rd_addr_q.size() != 16 || wr_addr_q.size() != 16) begin
            miscompares++;
            $display("FAIL page1_counts: reads=%0d writes=%0d, expected 16/16", rd_addr_q.size(), wr_addr_q.size());
        end
        for (int k = 0; k < 16 && k < rd_addr_q.size() && k < wr_addr_q.size(); k++) begin
            vectors++;
            if (rd_addr_q[k] != 16 + k || wr_addr_q[k] != 16 + k || wr_data_q[k] !== 32'h0000000C || wr_bx_q[k] != 1) begin
                miscompares++;
                $display("FAIL page1_entry%0d: rd=%0d wr=%0d data=%h bx=%0d, expected %0d %0d 0000000c 1",
                         k, rd_addr_q[k], wr_addr_q[k], wr_data_q[k], wr_bx_q[k], 16 + k, 16 + k);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_data [16];
        for (int k = 0; k < 16; k++) exp_data[k] = 32'h0000000C;
        mem1[3]  = 32'hFFFFFFFF; mem2[3]  = 32'h00000001; exp_data[3]  = 32'h00000000;
        mem1[9]  = 32'h80000000; mem2[9]  = 32'h80000000; exp_data[9]  = 32'h00000000;
        mem1[12] = 32'hFFFFFFFF; mem2[12] = 32'hFFFFFFFF; exp_data[12] = 32'hFFFFFFFE;
        mem1[14] = 32'h12345678; mem2[14] = 32'h11111111; exp_data[14] = 32'h23456789;
        clear_logs();
        bx_in = 2'd0;
        tick(30);
        vectors++;
        if (wr_addr_q.size() != 16) begin
            miscompares++;
            $display("FAIL wrap_count: writes=%0d, expected 16", wr_addr_q.size());
        end
        for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
            vectors++;
            if (wr_addr_q[k] != k || wr_data_q[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL wrap_entry%0d: addr=%0d data=%h, expected %0d %h",
                         k, wr_addr_q[k], wr_data_q[k], k, exp_data[k]);
            end
        end
        fill_mem();
    endtask

    task automatic test_abort();
        bit ok;
        clear_logs();
        bx_in = 2'd1;
        wait_read(5'd23, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL abort_wait: read of addr 23 not seen, expected within 40 cycles");
        end
        bx_in = 2'd2;
        tick(30);
        vectors++;
        if (rd_addr_q.size() != 24 || wr_addr_q.size() != 24) begin
            miscompares++;
            $display("FAIL abort_counts: reads=%0d writes=%0d, expected 24/24", rd_addr_q.size(), wr_addr_q.size());
        end
        for (int k = 0; k < 24 && k < rd_addr_q.size() && k < wr_addr_q.size(); k++) begin
            int ea;
            int eb;
            ea = (k < 8) ? 16 + k : k - 8;
            eb = (k < 8) ? 1 : 0;
            vectors++;
            if (rd_addr_q[k] != ea || wr_addr_q[k] != ea || wr_data_q[k] !== 32'h0000000C || wr_bx_q[k] != eb) begin
                miscompares++;
                $display("FAIL abort_entry%0d: rd=%0d wr=%0d data=%h bx=%0d, expected %0d %0d 0000000c %0d",
                         k, rd_addr_q[k], wr_addr_q[k], wr_data_q[k], wr_bx_q[k], ea, ea, eb);
            end
        end
    endtask

    task automatic test_en_gap();
        bit ok;
        clear_logs();
        bx_in = 2'd3;
        wait_read(5'd21, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL gap_wait: read of addr 21 not seen, expected within 40 cycles");
        end
        en_proc = 1'b0;
        tick(4);
        en_proc = 1'b1;
        tick(30);
        vectors++;
        if (rd_addr_q.size() != 16 || wr_addr_q.size() != 16) begin
            miscompares++;
            $display("FAIL gap_counts: reads=%0d writes=%0d, expected 16/16", rd_addr_q.size(), wr_addr_q.size());
        end
        for (int k = 0; k < 16 && k < rd_addr_q.size() && k < wr_addr_q.size(); k++) begin
            vectors++;
            if (rd_addr_q[k] != 16 + k || wr_addr_q[k] != 16 + k || wr_data_q[k] !== 32'h0000000C) begin
                miscompares++;
                $display("FAIL gap_entry%0d: rd=%0d wr=%0d data=%h, expected %0d %0d 0000000c",
                         k, rd_addr_q[k], wr_addr_q[k], wr_data_q[k], 16 + k, 16 + k);
            end
        end
        if (rd_cyc_q.size() > 6) begin
            vectors++;
            if (rd_cyc_q[6] - rd_cyc_q[5] != 5) begin
                miscompares++;
                $display("FAIL gap_stall: read gap %0d cycles, expected 5", rd_cyc_q[6] - rd_cyc_q[5]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        bx_in = 2'd0;
        wait_read(5'd4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstmid_wait: read of addr 4 not seen, expected within 40 cycles");
        end
        reset = 1'b1;
        tick(1);
        vectors++;
        if ({bx_out, mem1_enb, mem2_enb, mem1_readaddr, mem2_readaddr, memout_ena,
             memout_wea, memout_writeaddr, memout_din} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got ena=%b enb=%b waddr=%0d din=%h bx_out=%b, expected all 0",
                     memout_ena, mem1_enb, memout_writeaddr, memout_din, bx_out);
        end
        clear_logs();
        reset = 1'b0;
        tick(30);
        vectors++;
        if (wr_addr_q.size() != 16) begin
            miscompares++;
            $display("FAIL rstmid_count: writes=%0d, expected 16", wr_addr_q.size());
        end
        for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
            vectors++;
            if (wr_addr_q[k] != k || wr_data_q[k] !== 32'h0000000C || wr_bx_q[k] != 0) begin
                miscompares++;
                $display("FAIL rstmid_entry%0d: wr=%0d data=%h bx=%0d, expected %0d 0000000c 0",
                         k, wr_addr_q[k], wr_data_q[k], wr_bx_q[k], k);
            end
        end
    endtask

    initial begin
        fill_mem();
        reset = 1'b1; en_proc = 1'b0; bx_in = 2'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_page_switch();
        test_wrap();
        test_abort();
        test_en_gap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
